// File: rtl/dispatch_pkg.sv
// -----------------------------------------------------------------------------
// dispatch_pkg
// Shared constants for the sensor command dispatcher:
//   - host request codes and response codes
//   - top-level FSM state encoding
//   - response frame length and byte-index width
//   - checksum helper, present only when DISPATCH_CHECKSUM_EN is defined
// Build option: DISPATCH_CHECKSUM_EN appends an XOR checksum byte to every
// response frame.
// -----------------------------------------------------------------------------
package dispatch_pkg;

  // Host request codes
  localparam logic [7:0] REQ_STATUS = 8'h00;
  localparam logic [7:0] REQ_TEMP   = 8'h02;
  localparam logic [7:0] REQ_HUM    = 8'h03;

  // Response codes (first byte of every frame)
  localparam logic [7:0] RESP_OK       = 8'h00;
  localparam logic [7:0] RESP_TEMP     = 8'h01;
  localparam logic [7:0] RESP_HUM      = 8'h02;
  localparam logic [7:0] RESP_BAD_CMD  = 8'hE0;
  localparam logic [7:0] RESP_TIMEOUT  = 8'hE1;
  localparam logic [7:0] RESP_BAD_ADDR = 8'hE2;

  // FSM state encoding
  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_GET_ADDR = 3'd1;
  localparam logic [2:0] ST_CHECK    = 3'd2;
  localparam logic [2:0] ST_WAIT_IF  = 3'd3;
  localparam logic [2:0] ST_LOAD     = 3'd4;
  localparam logic [2:0] ST_SEND     = 3'd5;

`ifdef DISPATCH_CHECKSUM_EN
  localparam int unsigned FRAME_LEN = 4;
`else
  localparam int unsigned FRAME_LEN = 3;
`endif

  // Two bits cover both the 3- and 4-byte frame variants
  localparam int unsigned IDX_W = 2;

  // True for request codes the dispatcher knows how to serve
  function automatic logic req_is_known(input logic [7:0] req);
    logic known;
    case (req)
      REQ_STATUS: known = 1'b1;
      REQ_TEMP:   known = 1'b1;
      REQ_HUM:    known = 1'b1;
      default:    known = 1'b0;
    endcase
    return known;
  endfunction

`ifdef DISPATCH_CHECKSUM_EN
  // Checksum byte: XOR of the three payload bytes
  function automatic logic [7:0] frame_xor(input logic [7:0] b0,
                                           input logic [7:0] b1,
                                           input logic [7:0] b2);
    return b0 ^ b1 ^ b2;
  endfunction
`endif

endpackage

// File: rtl/resp_serializer.sv
// -----------------------------------------------------------------------------
// resp_serializer
// Holds one response frame and streams it byte by byte over a valid/ready
// handshake. When DISPATCH_CHECKSUM_EN is defined, a fourth byte (XOR of the
// first three) is appended.
// Ports:
//   i_Clock, i_Rst_n     clock, asynchronous active-low reset
//   i_load               one-cycle strobe: capture i_byte0..2, start sending
//   i_byte0..i_byte2     frame payload (response code, int, float)
//   i_tx_ready           downstream accepts byte when o_tx_valid & i_tx_ready
//   o_tx_valid/o_tx_data registered byte stream
//   o_frame_done         high in the cycle the last byte is accepted
// -----------------------------------------------------------------------------
module resp_serializer
  import dispatch_pkg::*;
(
  input  logic       i_Clock,
  input  logic       i_Rst_n,
  input  logic       i_load,
  input  logic [7:0] i_byte0,
  input  logic [7:0] i_byte1,
  input  logic [7:0] i_byte2,
  input  logic       i_tx_ready,
  output logic       o_tx_valid,
  output logic [7:0] o_tx_data,
  output logic       o_frame_done
);

  logic [7:0]       frame_q [FRAME_LEN];
  logic [7:0]       frame_d [FRAME_LEN];
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             valid_q, valid_d;
  logic [7:0]       data_q, data_d;
  logic             done_s;
  logic [IDX_W-1:0] idx_nxt_s;

  // Next-state logic for byte index, frame storage and output byte
  always_comb begin
    frame_d   = frame_q;
    idx_d     = idx_q;
    valid_d   = valid_q;
    data_d    = data_q;
    done_s    = 1'b0;
    idx_nxt_s = idx_q + {{(IDX_W-1){1'b0}}, 1'b1};
    if (i_load) begin
      frame_d[0] = i_byte0;
      frame_d[1] = i_byte1;
      frame_d[2] = i_byte2;
`ifdef DISPATCH_CHECKSUM_EN
      frame_d[3] = frame_xor(i_byte0, i_byte1, i_byte2);
`endif
      idx_d   = {IDX_W{1'b0}};
      valid_d = 1'b1;
      data_d  = i_byte0;
    end else if (valid_q && i_tx_ready) begin
      if (idx_q == IDX_W'(FRAME_LEN - 1)) begin
        idx_d   = {IDX_W{1'b0}};
        valid_d = 1'b0;
        data_d  = 8'h00;
        done_s  = 1'b1;
      end else begin
        // Next byte is presented on the handshake edge: no bubble between bytes
        idx_d  = idx_nxt_s;
        data_d = frame_q[idx_nxt_s];
      end
    end else begin
      idx_d = idx_q;
    end
  end

  // Serializer state registers
  always_ff @(posedge i_Clock or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      for (int i = 0; i < int'(FRAME_LEN); i++) begin
        frame_q[i] <= 8'h00;
      end
      idx_q   <= {IDX_W{1'b0}};
      valid_q <= 1'b0;
      data_q  <= 8'h00;
    end else begin
      frame_q <= frame_d;
      idx_q   <= idx_d;
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign o_tx_valid   = valid_q;
  assign o_tx_data    = data_q;
  assign o_frame_done = done_s;

endmodule

// File: rtl/sensor_cmd_dispatcher.sv
// -----------------------------------------------------------------------------
// sensor_cmd_dispatcher
// Assembles a 2-byte host command (request, address) from the UART receiver,
// validates it, runs the sensor interface with a timeout when a measurement is
// requested, and returns a fixed response frame {resp, int, float} to the
// UART transmitter.
// Build option: DISPATCH_CHECKSUM_EN adds an XOR checksum byte to the frame
// (handled inside resp_serializer).
// Parameters:
//   TIMEOUT_CYCLES  cycles allowed in WAIT_IF before a sensor timeout
//   ADDR_MAX        highest legal sensor address
// Ports:
//   i_Clock, i_Rst_n            clock, asynchronous active-low reset
//   i_rx_valid, i_rx_data       received byte strobe and data
//   o_if_en, o_if_request       sensor interface enable (level) and request
//   i_if_done, i_if_data_*      sensor done pulse and result bytes
//   o_tx_valid, o_tx_data       response byte stream
//   i_tx_ready                  transmitter ready
//   o_busy                      high outside IDLE and GET_ADDR
// -----------------------------------------------------------------------------
module sensor_cmd_dispatcher
  import dispatch_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 100000000,
  parameter logic [7:0]  ADDR_MAX       = 8'd31
) (
  input  logic       i_Clock,
  input  logic       i_Rst_n,
  input  logic       i_rx_valid,
  input  logic [7:0] i_rx_data,
  output logic       o_if_en,
  output logic [7:0] o_if_request,
  input  logic       i_if_done,
  input  logic [7:0] i_if_data_int,
  input  logic [7:0] i_if_data_float,
  output logic       o_tx_valid,
  output logic [7:0] o_tx_data,
  input  logic       i_tx_ready,
  output logic       o_busy
);

  localparam int unsigned     CNT_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [2:0]       state_q, state_d;
  logic [7:0]       req_q, req_d;
  logic [7:0]       addr_q, addr_d;
  logic [7:0]       resp_q, resp_d;
  logic [7:0]       int_q, int_d;
  logic [7:0]       flt_q, flt_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             if_en_q, if_en_d;
  logic [7:0]       if_req_q, if_req_d;
  logic             busy_q, busy_d;
  logic             load_s;
  logic             frame_done_s;

  // Command FSM: byte assembly, validation, sensor wait and frame hand-off
  always_comb begin
    state_d  = state_q;
    req_d    = req_q;
    addr_d   = addr_q;
    resp_d   = resp_q;
    int_d    = int_q;
    flt_d    = flt_q;
    cnt_d    = cnt_q;
    if_en_d  = if_en_q;
    if_req_d = if_req_q;
    load_s   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (i_rx_valid) begin
          req_d   = i_rx_data;
          state_d = ST_GET_ADDR;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_GET_ADDR: begin
        if (i_rx_valid) begin
          addr_d  = i_rx_data;
          state_d = ST_CHECK;
        end else begin
          state_d = ST_GET_ADDR;
        end
      end
      ST_CHECK: begin
        // Address is judged before the request code
        if (addr_q > ADDR_MAX) begin
          resp_d  = RESP_BAD_ADDR;
          int_d   = 8'h00;
          flt_d   = 8'h00;
          state_d = ST_LOAD;
        end else if (!req_is_known(req_q)) begin
          resp_d  = RESP_BAD_CMD;
          int_d   = 8'h00;
          flt_d   = 8'h00;
          state_d = ST_LOAD;
        end else if (req_q == REQ_STATUS) begin
          resp_d  = RESP_OK;
          int_d   = 8'h00;
          flt_d   = 8'h00;
          state_d = ST_LOAD;
        end else begin
          if_req_d = req_q;
          if_en_d  = 1'b1;
          cnt_d    = {CNT_W{1'b0}};
          state_d  = ST_WAIT_IF;
        end
      end
      ST_WAIT_IF: begin
        // A done pulse in the final timeout cycle still counts as success
        if (i_if_done) begin
          int_d   = i_if_data_int;
          flt_d   = i_if_data_float;
          resp_d  = (req_q == REQ_TEMP) ? RESP_TEMP : RESP_HUM;
          if_en_d = 1'b0;
          state_d = ST_LOAD;
        end else if (cnt_q == CNT_LAST) begin
          resp_d  = RESP_TIMEOUT;
          int_d   = 8'h00;
          flt_d   = 8'h00;
          if_en_d = 1'b0;
          state_d = ST_LOAD;
        end else begin
          cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
      end
      ST_LOAD: begin
        load_s  = 1'b1;
        state_d = ST_SEND;
      end
      ST_SEND: begin
        if (frame_done_s) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_SEND;
        end
      end
      default: begin
        if_en_d = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
    busy_d = !((state_d == ST_IDLE) || (state_d == ST_GET_ADDR));
  end

  // FSM and output registers
  always_ff @(posedge i_Clock or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      state_q  <= ST_IDLE;
      req_q    <= 8'h00;
      addr_q   <= 8'h00;
      resp_q   <= 8'h00;
      int_q    <= 8'h00;
      flt_q    <= 8'h00;
      cnt_q    <= {CNT_W{1'b0}};
      if_en_q  <= 1'b0;
      if_req_q <= 8'h00;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      req_q    <= req_d;
      addr_q   <= addr_d;
      resp_q   <= resp_d;
      int_q    <= int_d;
      flt_q    <= flt_d;
      cnt_q    <= cnt_d;
      if_en_q  <= if_en_d;
      if_req_q <= if_req_d;
      busy_q   <= busy_d;
    end
  end

  resp_serializer u_resp_serializer (
    .i_Clock      (i_Clock),
    .i_Rst_n      (i_Rst_n),
    .i_load       (load_s),
    .i_byte0      (resp_q),
    .i_byte1      (int_q),
    .i_byte2      (flt_q),
    .i_tx_ready   (i_tx_ready),
    .o_tx_valid   (o_tx_valid),
    .o_tx_data    (o_tx_data),
    .o_frame_done (frame_done_s)
  );

  assign o_if_en      = if_en_q;
  assign o_if_request = if_req_q;
  assign o_busy       = busy_q;

endmodule

// File: tb/tb_sensor_cmd_dispatcher.sv
// -----------------------------------------------------------------------------
// tb_sensor_cmd_dispatcher
// Directed bench. Two dispatcher instances share one set of drive signals:
// instance A (long timeout) for normal traffic, instance B (TIMEOUT_CYCLES=16)
// for timeout scenarios; 'sel' routes stimulus and observation to one of them.
// Build option: DISPATCH_CHECKSUM_EN expects the 4-byte frame.
// -----------------------------------------------------------------------------
module tb_sensor_cmd_dispatcher;
  import dispatch_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       sel;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic       if_done;
  logic [7:0] if_int, if_flt;
  logic       tx_ready;

  logic       a_if_en, b_if_en, a_tx_valid, b_tx_valid, a_busy, b_busy;
  logic [7:0] a_if_req, b_if_req, a_tx_data, b_tx_data;
  logic       if_en, tx_valid, busy;
  logic [7:0] if_req, tx_data;

  int         n_vec = 0;
  int         n_err = 0;
  logic [7:0] fr [0:3];
  logic [7:0] exp_f [0:3];
  int         fr_n, fr_gaps, lat;
  logic       en_seen;

  always #5 clk = ~clk;

  sensor_cmd_dispatcher #(.TIMEOUT_CYCLES(1000), .ADDR_MAX(8'd31)) dut_a (
    .i_Clock(clk), .i_Rst_n(rst_n),
    .i_rx_valid(rx_valid & ~sel), .i_rx_data(rx_data),
    .o_if_en(a_if_en), .o_if_request(a_if_req),
    .i_if_done(if_done & ~sel), .i_if_data_int(if_int), .i_if_data_float(if_flt),
    .o_tx_valid(a_tx_valid), .o_tx_data(a_tx_data), .i_tx_ready(tx_ready & ~sel),
    .o_busy(a_busy)
  );

  sensor_cmd_dispatcher #(.TIMEOUT_CYCLES(16), .ADDR_MAX(8'd31)) dut_b (
    .i_Clock(clk), .i_Rst_n(rst_n),
    .i_rx_valid(rx_valid & sel), .i_rx_data(rx_data),
    .o_if_en(b_if_en), .o_if_request(b_if_req),
    .i_if_done(if_done & sel), .i_if_data_int(if_int), .i_if_data_float(if_flt),
    .o_tx_valid(b_tx_valid), .o_tx_data(b_tx_data), .i_tx_ready(tx_ready & sel),
    .o_busy(b_busy)
  );

  assign if_en    = sel ? b_if_en    : a_if_en;
  assign if_req   = sel ? b_if_req   : a_if_req;
  assign tx_valid = sel ? b_tx_valid : a_tx_valid;
  assign tx_data  = sel ? b_tx_data  : a_tx_data;
  assign busy     = sel ? b_busy     : a_busy;

  task automatic set_exp(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
    exp_f[0] = b0; exp_f[1] = b1; exp_f[2] = b2; exp_f[3] = b0 ^ b1 ^ b2;
  endtask

  task automatic send_cmd(input logic [7:0] b0, input logic [7:0] b1);
    @(negedge clk); rx_valid = 1'b1; rx_data = b0;
    @(negedge clk); rx_data = b1;
    @(negedge clk); rx_valid = 1'b0; rx_data = 8'h00;
  endtask

  task automatic pulse_done(input logic [7:0] i, input logic [7:0] f);
    if_int = i; if_flt = f; if_done = 1'b1;
    @(negedge clk); if_done = 1'b0; if_int = 8'h00; if_flt = 8'h00;
  endtask

  task automatic wait_en();
    int c = 0;
    while (if_en !== 1'b1 && c < 50) begin @(negedge clk); c++; end
  endtask

  task automatic wait_valid();
    lat = 0; en_seen = 1'b0;
    while (tx_valid !== 1'b1 && lat < 50) begin
      @(negedge clk); lat++;
      if (if_en === 1'b1) en_seen = 1'b1;
    end
  endtask

  // Collect one frame, sampling on negedges; counts idle cycles inside the frame
  task automatic recv_frame();
    logic started = 1'b0;
    fr_n = 0; fr_gaps = 0;
    for (int c = 0; c < 200 && fr_n < int'(FRAME_LEN); c++) begin
      if (tx_valid === 1'b1 && tx_ready === 1'b1) begin
        fr[fr_n] = tx_data; fr_n++; started = 1'b1;
      end else if (started) begin
        fr_gaps++;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    for (int s = 0; s < 2; s++) begin
      sel = s[0]; #1;
      n_vec++;
      if ({if_en, if_req, tx_valid, tx_data, busy} !== 19'd0) begin
        n_err++;
        $display("FAIL reset_outputs dut%0d: got en=%b req=%h v=%b d=%h busy=%b expected all 0",
                 s, if_en, if_req, tx_valid, tx_data, busy);
      end
    end
    sel = 1'b0;
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_temperature();
    sel = 1'b0; tx_ready = 1'b1;
    send_cmd(8'h02, 8'h05);
    n_vec++;
    if (busy !== 1'b1) begin n_err++; $display("FAIL temp_busy: got %b expected 1", busy); end
    wait_en();
    n_vec++;
    if (if_req !== 8'h02) begin n_err++; $display("FAIL temp_if_request: got %h expected 02", if_req); end
    repeat (39) @(negedge clk);
    n_vec++;
    if (if_en !== 1'b1) begin n_err++; $display("FAIL temp_en_held: got %b expected 1", if_en); end
    pulse_done(8'h19, 8'h03);
    n_vec++;
    if (if_en !== 1'b0) begin n_err++; $display("FAIL temp_en_drop: got %b expected 0", if_en); end
    set_exp(8'h01, 8'h19, 8'h03);
    recv_frame();
    n_vec++;
    if (fr_n !== int'(FRAME_LEN)) begin n_err++; $display("FAIL temp_len: got %0d expected %0d", fr_n, FRAME_LEN); end
    for (int k = 0; k < int'(FRAME_LEN); k++) begin
      n_vec++;
      if (fr[k] !== exp_f[k]) begin n_err++; $display("FAIL temp_byte%0d: got %h expected %h", k, fr[k], exp_f[k]); end
    end
    n_vec++;
    if (fr_gaps !== 0) begin n_err++; $display("FAIL temp_gaps: got %0d expected 0", fr_gaps); end
`ifdef DISPATCH_CHECKSUM_EN
    n_vec++;
    if (fr[3] !== 8'h1B) begin n_err++; $display("FAIL temp_checksum: got %h expected 1b", fr[3]); end
`endif
    n_vec++;
    if ({tx_valid, busy} !== 2'b00) begin n_err++; $display("FAIL temp_end: got v=%b busy=%b expected 0 0", tx_valid, busy); end
  endtask

  task automatic test_ready_toggle();
    sel = 1'b0; tx_ready = 1'b0;
    send_cmd(8'h03, 8'h00);
    wait_en();
    pulse_done(8'h3C, 8'h00);
    wait_valid();
    set_exp(8'h02, 8'h3C, 8'h00);
    for (int k = 0; k < int'(FRAME_LEN); k++) begin
      tx_ready = 1'b0;
      repeat (2) begin
        @(negedge clk);
        n_vec++;
        if ({tx_valid, tx_data} !== {1'b1, exp_f[k]}) begin
          n_err++;
          $display("FAIL hold_byte%0d: got v=%b d=%h expected v=1 d=%h", k, tx_valid, tx_data, exp_f[k]);
        end
      end
      tx_ready = 1'b1;
      @(negedge clk);
    end
    n_vec++;
    if ({tx_valid, busy} !== 2'b00) begin n_err++; $display("FAIL hold_end: got v=%b busy=%b expected 0 0", tx_valid, busy); end
  endtask

  task automatic test_reject_paths();
    logic [7:0] cmd_req  [0:4] = '{8'h07, 8'h02, 8'h07, 8'h00, 8'h00};
    logic [7:0] cmd_addr [0:4] = '{8'h01, 8'h40, 8'h40, 8'h1F, 8'h20};
    logic [7:0] cmd_resp [0:4] = '{8'hE0, 8'hE2, 8'hE2, 8'h00, 8'hE2};
    sel = 1'b0; tx_ready = 1'b1;
    for (int v = 0; v < 5; v++) begin
      send_cmd(cmd_req[v], cmd_addr[v]);
      wait_valid();
      n_vec++;
      if (lat + 1 !== 3) begin n_err++; $display("FAIL reject%0d_latency: got %0d expected 3", v, lat + 1); end
      n_vec++;
      if (en_seen !== 1'b0) begin n_err++; $display("FAIL reject%0d_if_en: got %b expected 0", v, en_seen); end
      set_exp(cmd_resp[v], 8'h00, 8'h00);
      recv_frame();
      for (int k = 0; k < int'(FRAME_LEN); k++) begin
        n_vec++;
        if (fr[k] !== exp_f[k]) begin n_err++; $display("FAIL reject%0d_byte%0d: got %h expected %h", v, k, fr[k], exp_f[k]); end
      end
    end
  endtask

  task automatic test_timeout();
    int cnt = 0;
    sel = 1'b1; tx_ready = 1'b1;
    send_cmd(8'h02, 8'h01);
    wait_en();
    while (if_en === 1'b1 && cnt < 100) begin cnt++; @(negedge clk); end
    n_vec++;
    if (cnt !== 16) begin n_err++; $display("FAIL timeout_en_cycles: got %0d expected 16", cnt); end
    set_exp(8'hE1, 8'h00, 8'h00);
    recv_frame();
    for (int k = 0; k < int'(FRAME_LEN); k++) begin
      n_vec++;
      if (fr[k] !== exp_f[k]) begin n_err++; $display("FAIL timeout_byte%0d: got %h expected %h", k, fr[k], exp_f[k]); end
    end
  endtask

  task automatic test_done_vs_timeout();
    sel = 1'b1; tx_ready = 1'b1;
    send_cmd(8'h02, 8'h01);
    wait_en();
    repeat (15) @(negedge clk);
    n_vec++;
    if (if_en !== 1'b1) begin n_err++; $display("FAIL race_en_before: got %b expected 1", if_en); end
    pulse_done(8'h55, 8'h66);
    n_vec++;
    if (if_en !== 1'b0) begin n_err++; $display("FAIL race_en_after: got %b expected 0", if_en); end
    set_exp(8'h01, 8'h55, 8'h66);
    recv_frame();
    for (int k = 0; k < int'(FRAME_LEN); k++) begin
      n_vec++;
      if (fr[k] !== exp_f[k]) begin n_err++; $display("FAIL race_byte%0d: got %h expected %h", k, fr[k], exp_f[k]); end
    end
    sel = 1'b0;
  endtask

  task automatic test_drop_while_busy();
    sel = 1'b0; tx_ready = 1'b0;
    send_cmd(8'h02, 8'h05);
    wait_en();
    send_cmd(8'h00, 8'h00);
    pulse_done(8'h11, 8'h22);
    wait_valid();
    @(negedge clk); rx_valid = 1'b1; rx_data = 8'h07;
    @(negedge clk); rx_valid = 1'b0; rx_data = 8'h00;
    tx_ready = 1'b1;
    set_exp(8'h01, 8'h11, 8'h22);
    recv_frame();
    for (int k = 0; k < int'(FRAME_LEN); k++) begin
      n_vec++;
      if (fr[k] !== exp_f[k]) begin n_err++; $display("FAIL drop_byte%0d: got %h expected %h", k, fr[k], exp_f[k]); end
    end
    n_vec++;
    if (busy !== 1'b0) begin n_err++; $display("FAIL drop_idle: got busy=%b expected 0", busy); end
    send_cmd(8'h00, 8'h00);
    wait_valid();
    set_exp(8'h00, 8'h00, 8'h00);
    recv_frame();
    n_vec++;
    if (fr_n !== int'(FRAME_LEN) || fr[0] !== 8'h00) begin
      n_err++; $display("FAIL drop_next_cmd: got n=%0d resp=%h expected n=%0d resp=00", fr_n, fr[0], FRAME_LEN);
    end
  endtask

  task automatic test_reset_mid_op();
    sel = 1'b0; tx_ready = 1'b1;
    send_cmd(8'h02, 8'h05);
    wait_en();
    @(negedge clk); rst_n = 1'b0; #1;
    n_vec++;
    if (if_en !== 1'b0) begin n_err++; $display("FAIL rst_async_en: got %b expected 0", if_en); end
    @(negedge clk); rst_n = 1'b1;
    tx_ready = 1'b0;
    send_cmd(8'h02, 8'h05);
    wait_en();
    pulse_done(8'h19, 8'h03);
    wait_valid();
    tx_ready = 1'b1;
    @(negedge clk); tx_ready = 1'b0;
    n_vec++;
    if ({tx_valid, tx_data} !== {1'b1, 8'h19}) begin n_err++; $display("FAIL rst_pre_byte1: got v=%b d=%h expected v=1 d=19", tx_valid, tx_data); end
    rst_n = 1'b0; #1;
    n_vec++;
    if ({if_en, if_req, tx_valid, tx_data, busy} !== 19'd0) begin
      n_err++;
      $display("FAIL rst_mid_send: got en=%b req=%h v=%b d=%h busy=%b expected all 0", if_en, if_req, tx_valid, tx_data, busy);
    end
    @(negedge clk); rst_n = 1'b1; tx_ready = 1'b1;
    send_cmd(8'h07, 8'h05);
    wait_valid();
    set_exp(8'hE0, 8'h00, 8'h00);
    recv_frame();
    for (int k = 0; k < int'(FRAME_LEN); k++) begin
      n_vec++;
      if (fr[k] !== exp_f[k]) begin n_err++; $display("FAIL rst_next_byte%0d: got %h expected %h", k, fr[k], exp_f[k]); end
    end
  endtask

  task automatic test_done_ignored_idle();
    sel = 1'b0;
    @(negedge clk);
    pulse_done(8'hAA, 8'hBB);
    repeat (3) @(negedge clk);
    n_vec++;
    if ({if_en, tx_valid, busy} !== 3'b000) begin
      n_err++; $display("FAIL idle_done: got en=%b v=%b busy=%b expected 0 0 0", if_en, tx_valid, busy);
    end
  endtask

  initial begin
    rst_n = 1'b0; sel = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
    if_done = 1'b0; if_int = 8'h00; if_flt = 8'h00; tx_ready = 1'b0;
    repeat (2) @(negedge clk);
    test_reset();
    test_temperature();
    test_ready_toggle();
    test_reject_paths();
    test_timeout();
    test_done_vs_timeout();
    test_drop_while_busy();
    test_reset_mid_op();
    test_done_ignored_idle();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
